// File: rtl/trace_capture_unit.sv
// trace_capture_unit: pairs completed data-memory accesses with their instructions and streams them as trace entries
//
// Ports:
//    clk, rst            clock, asynchronous active-high reset
//    capture_start_i     arm capture, clear counters and sticky flags
//    capture_stop_i      stop tracking new accesses, drain what is pending
//    data_req_i/gnt_i    core request / memory grant; a handshake is tracked
//    data_we_i           1 = store
//    data_addr_i         request address
//    data_instr_i        issuing instruction
//    data_rvalid_i       in-order response; retires the oldest tracked access
//    lock_i              repository locked; hold emission
//    trace_addr_o/instr  emitted entry, held while trace_valid_o=0
//    trace_valid_o       one-cycle strobe per emitted entry
//    capture_done_o      stopped and fully drained
//    captured_count_o    entries emitted (saturating)
//    dropped_count_o     entries lost to a full buffer (saturating)
//    overflow_o          sticky: at least one drop
//    proto_err_o         sticky: grant with tracker full, or rvalid with tracker empty
//
// Build option: define TRACE_CAPTURE_STORES_EN to emit stores as well as loads;
// otherwise completed stores are retired silently.
module trace_capture_unit #(
   parameter int DATA_ADDR_WIDTH = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int OUTSTANDING = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       capture_start_i,
   input  logic                       capture_stop_i,
   input  logic                       data_req_i,
   input  logic                       data_gnt_i,
   input  logic                       data_we_i,
   input  logic [DATA_ADDR_WIDTH-1:0] data_addr_i,
   input  logic [INSTR_WIDTH-1:0]     data_instr_i,
   input  logic                       data_rvalid_i,
   input  logic                       lock_i,
   output logic [DATA_ADDR_WIDTH-1:0] trace_addr_o,
   output logic [INSTR_WIDTH-1:0]     trace_instr_o,
   output logic                       trace_valid_o,
   output logic                       capture_done_o,
   output logic [15:0]                captured_count_o,
   output logic [15:0]                dropped_count_o,
   output logic                       overflow_o,
   output logic                       proto_err_o
);
   localparam int TW = $clog2(OUTSTANDING);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_ADDR_WIDTH + INSTR_WIDTH;
   localparam logic [TW:0] T_ONE = 1;
   localparam logic [FW:0] F_ONE = 1;
`ifdef TRACE_CAPTURE_STORES_EN
   localparam logic STORES = 1'b1;
`else
   localparam logic STORES = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [EW:0]   trk [OUTSTANDING];
   logic [EW-1:0] fifo [FIFO_DEPTH];
   logic [TW:0]   t_wr, t_rd;
   logic [FW:0]   f_wr, f_rd;
   logic [EW:0]   head;
   logic [EW-1:0] emit_data;
   logic t_empty, t_full, f_empty, f_full, active, start;
   logic grant, push, pop, complete, emit, f_push, f_pop, drop;

   assign start    = capture_start_i & ~capture_stop_i;
   assign active   = (state == CAPTURE) | (state == DRAIN);
   assign t_empty  = t_wr == t_rd;
   assign t_full   = (t_wr ^ t_rd) == {1'b1, {TW{1'b0}}};
   assign f_empty  = f_wr == f_rd;
   assign f_full   = (f_wr ^ f_rd) == {1'b1, {FW{1'b0}}};
   assign grant    = (state == CAPTURE) & data_req_i & data_gnt_i;
   assign push     = grant & ~t_full;
   assign pop      = active & data_rvalid_i & ~t_empty;
   assign head     = trk[t_rd[TW-1:0]];
   assign complete = pop & (STORES | ~head[0]);
   // An empty buffer lets a just-completed entry bypass straight to the output
   assign emit      = ~lock_i & (~f_empty | complete);
   assign emit_data = f_empty ? head[EW:1] : fifo[f_rd[FW-1:0]];
   assign f_pop     = emit & ~f_empty;
   assign drop      = complete & f_full & ~emit;
   assign f_push    = complete & ~(emit & f_empty) & ~drop;
   assign capture_done_o = state == DONE;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? CAPTURE : IDLE;
         CAPTURE: state_nxt = capture_stop_i ? DRAIN : CAPTURE;
         DRAIN:   state_nxt = (t_empty & f_empty & ~trace_valid_o) ? DONE : DRAIN;
         DONE:    state_nxt = start ? CAPTURE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         t_wr             <= '0;
         t_rd             <= '0;
         f_wr             <= '0;
         f_rd             <= '0;
         trace_addr_o     <= '0;
         trace_instr_o    <= '0;
         trace_valid_o    <= 1'b0;
         captured_count_o <= '0;
         dropped_count_o  <= '0;
         overflow_o       <= 1'b0;
         proto_err_o      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) t_wr <= t_wr + T_ONE;
         if (pop) t_rd <= t_rd + T_ONE;
         if (f_push) f_wr <= f_wr + F_ONE;
         if (f_pop) f_rd <= f_rd + F_ONE;
         if (emit) begin
            trace_addr_o  <= emit_data[EW-1:INSTR_WIDTH];
            trace_instr_o <= emit_data[INSTR_WIDTH-1:0];
         end
         trace_valid_o    <= emit;
         captured_count_o <= start ? '0 : captured_count_o + 16'(emit & ~&captured_count_o);
         dropped_count_o  <= start ? '0 : dropped_count_o + 16'(drop & ~&dropped_count_o);
         overflow_o       <= ~start & (overflow_o | drop);
         proto_err_o      <= ~start & (proto_err_o | (grant & t_full) | (active & data_rvalid_i & t_empty));
      end
   end

   always_ff @(posedge clk) begin
      if (push) trk[t_wr[TW-1:0]] <= {data_addr_i, data_instr_i, data_we_i};
      if (f_push) fifo[f_wr[FW-1:0]] <= head[EW:1];
   end
endmodule
